// File: rtl/stage_if_prefetch.sv
// ---------------------------------------------------------------------------
// stage_if_prefetch
//
// Instruction fetch stage with a DEPTH-entry prefetch FIFO of {pc, inst}
// pairs. Only one memory read is outstanding at a time. Returned
// instructions are queued so that ID can consume one per cycle without
// stalling. A taken branch flushes the queue, redirects the fetch pc and
// drops the result of any read that is still in flight.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   br          redirect request (one-cycle pulse)
//   br_addr     redirect target, valid with br
//   id_stall    ID cannot accept the head entry this cycle
//   mem_busy    memory controller cannot accept a new read
//   mem_done    one-cycle pulse, mem_data_i holds the outstanding read data
//   mem_data_i  read data
//   mem_re      read request, one pulse per issued read
//   mem_addr_o  read address while mem_re is high, otherwise 0
//   pc_o        pc of the FIFO head, 0 when empty
//   inst_o      instruction at the FIFO head, 0 when empty
//   inst_valid  FIFO is non-empty
//   stallreq    ID must insert a bubble (FIFO empty)
// ---------------------------------------------------------------------------
module stage_if_prefetch #(
    parameter int ADDR_W  = 32,
    parameter int INST_W  = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              br,
    input  logic [ADDR_W-1:0] br_addr,
    input  logic              id_stall,
    input  logic              mem_busy,
    input  logic              mem_done,
    input  logic [INST_W-1:0] mem_data_i,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [INST_W-1:0] inst_o,
    output logic              inst_valid,
    output logic              stallreq
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DISCARD
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0]   issued_pc_q, issued_pc_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [ADDR_W-1:0]   fifo_pc_q [DEPTH];
    logic [ADDR_W-1:0]   fifo_pc_d [DEPTH];
    logic [INST_W-1:0]   fifo_inst_q [DEPTH];
    logic [INST_W-1:0]   fifo_inst_d [DEPTH];

    logic has_room;
    logic push;
    logic pop;

    // Head-of-queue view for ID; everything reads zero when the queue is empty.
    always_comb begin
        inst_valid = (count_q != '0);
        stallreq   = !inst_valid;
        pc_o       = inst_valid ? fifo_pc_q[rd_ptr_q]   : '0;
        inst_o     = inst_valid ? fifo_inst_q[rd_ptr_q] : '0;
    end

    // Fetch control, queue bookkeeping and next-state logic.
    // Only one read is ever outstanding and reads only start from IDLE, so
    // checking for a free slot at issue time is enough to guarantee the
    // returning push always has room. A pop in the same cycle is not counted
    // as free space until the following cycle.
    always_comb begin
        state_d     = state_q;
        fetch_pc_d  = fetch_pc_q;
        issued_pc_d = issued_pc_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        fifo_pc_d   = fifo_pc_q;
        fifo_inst_d = fifo_inst_q;

        has_room   = (count_q < CNT_W'(DEPTH));
        mem_re     = (state_q == ST_IDLE) && !mem_busy && !br && !rst && has_room;
        mem_addr_o = mem_re ? fetch_pc_q : '0;
        push       = (state_q == ST_WAIT) && mem_done && !br;
        pop        = inst_valid && !id_stall && !br;

        if (br) begin
            // Redirect: flush the queue and drop whatever is in flight. A read
            // returning in this same cycle is simply not pushed.
            fetch_pc_d = br_addr;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            if (state_q != ST_IDLE) begin
                state_d = mem_done ? ST_IDLE : ST_DISCARD;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (mem_re) begin
                        issued_pc_d = fetch_pc_q;
                        fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_STEP);
                        state_d     = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_DISCARD: begin
                    if (mem_done) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            if (push) begin
                fifo_pc_d[wr_ptr_q]   = issued_pc_q;
                fifo_inst_d[wr_ptr_q] = mem_data_i;
                wr_ptr_d              = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    // State registers. Queue storage is not cleared on reset because the
    // count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            fetch_pc_q  <= '0;
            issued_pc_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            issued_pc_q <= issued_pc_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
        fifo_pc_q   <= fifo_pc_d;
        fifo_inst_q <= fifo_inst_d;
    end

endmodule

// File: tb/tb_stage_if_prefetch.sv
// ---------------------------------------------------------------------------
// tb_stage_if_prefetch
//
// Directed bench for stage_if_prefetch. A small memory model answers every
// issued read after a fixed latency. Each test pushes the read addresses it
// expects and the pcs it expects ID to consume into two queues; a monitor
// pops and compares whenever the DUT issues a read or ID consumes an entry.
// ---------------------------------------------------------------------------
module tb_stage_if_prefetch;

    localparam int ADDR_W  = 32;
    localparam int INST_W  = 32;
    localparam int DEPTH   = 4;
    localparam int PC_STEP = 4;
    localparam int LAT     = 2;

    logic              clk;
    logic              rst;
    logic              br;
    logic [ADDR_W-1:0] br_addr;
    logic              id_stall;
    logic              mem_busy;
    logic              mem_done;
    logic [INST_W-1:0] mem_data_i;
    logic              mem_re;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic              inst_valid;
    logic              stallreq;

    int checks = 0;
    int errors = 0;

    logic [ADDR_W-1:0] exp_addr_q [$];
    logic [ADDR_W-1:0] exp_pc_q   [$];

    stage_if_prefetch #(
        .ADDR_W (ADDR_W),
        .INST_W (INST_W),
        .DEPTH  (DEPTH),
        .PC_STEP(PC_STEP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .br        (br),
        .br_addr   (br_addr),
        .id_stall  (id_stall),
        .mem_busy  (mem_busy),
        .mem_done  (mem_done),
        .mem_data_i(mem_data_i),
        .mem_re    (mem_re),
        .mem_addr_o(mem_addr_o),
        .pc_o      (pc_o),
        .inst_o    (inst_o),
        .inst_valid(inst_valid),
        .stallreq  (stallreq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction word stored at a given address in the memory model.
    function automatic logic [INST_W-1:0] inst_of(input logic [ADDR_W-1:0] a);
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, outputs are sampled
    // on the falling edge.
    task automatic applyStimulus(input logic r, input logic b,
                                 input logic [ADDR_W-1:0] ba,
                                 input logic st, input logic bz);
        @(posedge clk);
        #2;
        rst      = r;
        br       = b;
        br_addr  = ba;
        id_stall = st;
        mem_busy = bz;
    endtask

    task automatic runCycles(input int n, input logic st, input logic bz);
        repeat (n) applyStimulus(1'b0, 1'b0, '0, st, bz);
    endtask

    task automatic resetDut();
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("rst_mem_re",     32'(mem_re),     32'd0);
        checkOutput("rst_mem_addr",   mem_addr_o,      32'd0);
        checkOutput("rst_pc",         pc_o,            32'd0);
        checkOutput("rst_inst",       inst_o,          32'd0);
        checkOutput("rst_inst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_stallreq",   32'(stallreq),   32'd1);
    endtask

    task automatic drainCheck(input string name);
        runCycles(6, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput({name, "_addr_left"}, 32'(exp_addr_q.size()), 32'd0);
        checkOutput({name, "_pc_left"},   32'(exp_pc_q.size()),   32'd0);
        exp_addr_q.delete();
        exp_pc_q.delete();
    endtask

    // Memory model: one outstanding read, answered LAT cycles after issue.
    // A reset aborts the read in flight.
    logic              m_re_s, m_rst_s, m_pend;
    logic [ADDR_W-1:0] m_addr_s, m_paddr;
    int                m_cnt;
    initial begin
        mem_done   = 1'b0;
        mem_data_i = '0;
        m_pend     = 1'b0;
        m_paddr    = '0;
        m_cnt      = 0;
        forever begin
            @(posedge clk);
            m_re_s   = mem_re;
            m_addr_s = mem_addr_o;
            m_rst_s  = rst;
            #1;
            mem_done   = 1'b0;
            mem_data_i = '0;
            if (m_rst_s) begin
                m_pend = 1'b0;
            end else begin
                if (m_pend) begin
                    m_cnt--;
                    if (m_cnt == 0) begin
                        mem_done   = 1'b1;
                        mem_data_i = inst_of(m_paddr);
                        m_pend     = 1'b0;
                    end
                end
                if (m_re_s) begin
                    m_pend  = 1'b1;
                    m_cnt   = LAT - 1;
                    m_paddr = m_addr_s;
                end
            end
        end
    end

    // Monitor: compare every issued read and every consumed entry against
    // the expectation queues.
    initial begin
        logic [ADDR_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_re) begin
                    if (exp_addr_q.size() == 0) begin
                        checkOutput("unexpected_mem_re", mem_addr_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_addr_q.pop_front();
                        checkOutput("sb_mem_addr", mem_addr_o, e);
                    end
                end
                if (inst_valid && !id_stall && !br) begin
                    if (exp_pc_q.size() == 0) begin
                        checkOutput("unexpected_pop", pc_o, 32'hFFFF_FFFF);
                    end else begin
                        e = exp_pc_q.pop_front();
                        checkOutput("sb_pc",   pc_o,   e);
                        checkOutput("sb_inst", inst_o, inst_of(e));
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog timeout");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [9:0] re_pat;
        logic [9:0] val_pat;
        rst      = 1'b1;
        br       = 1'b0;
        br_addr  = '0;
        id_stall = 1'b0;
        mem_busy = 1'b1;

        // Streaming with latency 2: reads at 0, 3, 6; entries at 3, 6, 9.
        $display("[TB] test 1: streaming");
        resetDut();
        exp_addr_q = '{32'h0, 32'h4, 32'h8};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8};
        re_pat  = 10'b0001001001;
        val_pat = 10'b1001001000;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, (k >= 7));
            @(negedge clk);
            checkOutput("t1_mem_re",     32'(mem_re),     32'(re_pat[k]));
            checkOutput("t1_inst_valid", 32'(inst_valid), 32'(val_pat[k]));
        end
        drainCheck("t1");

        // Full queue with ID stalled, then release.
        $display("[TB] test 2: full queue");
        resetDut();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        exp_pc_q   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
        runCycles(12, 1'b1, 1'b0);
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
            @(negedge clk);
            checkOutput("t2_full_mem_re", 32'(mem_re),     32'd0);
            checkOutput("t2_full_valid",  32'(inst_valid), 32'd1);
            checkOutput("t2_full_pc",     pc_o,            32'h0);
        end
        runCycles(2, 1'b0, 1'b0);
        drainCheck("t2");

        // Redirect while the read of 0x8 is in flight.
        $display("[TB] test 3: redirect during read");
        resetDut();
        exp_addr_q = '{32'h0, 32'h4, 32'h8, 32'h100};
        exp_pc_q   = '{32'h100};
        runCycles(7, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t3_br_mem_re", 32'(mem_re), 32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_flush_valid",    32'(inst_valid), 32'd0);
        checkOutput("t3_flush_stallreq", 32'(stallreq),   32'd1);
        checkOutput("t3_discard_mem_re", 32'(mem_re),     32'd0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t3_redir_mem_re", 32'(mem_re), 32'd1);
        checkOutput("t3_redir_addr",   mem_addr_o,  32'h100);
        drainCheck("t3");

        // Redirect in the same cycle as mem_done.
        $display("[TB] test 4: redirect with mem_done");
        resetDut();
        exp_addr_q = '{32'h0, 32'h200};
        exp_pc_q   = '{32'h200};
        runCycles(2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h200, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_mem_re", 32'(mem_re),     32'd1);
        checkOutput("t4_addr",   mem_addr_o,      32'h200);
        checkOutput("t4_valid",  32'(inst_valid), 32'd0);
        drainCheck("t4");

        // Memory busy for five cycles.
        $display("[TB] test 5: memory busy");
        resetDut();
        exp_addr_q = '{32'h0};
        exp_pc_q   = '{32'h0};
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
            @(negedge clk);
            checkOutput("t5_busy_mem_re",   32'(mem_re),   32'd0);
            checkOutput("t5_busy_stallreq", 32'(stallreq), 32'd1);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t5_free_mem_re", 32'(mem_re), 32'd1);
        checkOutput("t5_free_addr",   mem_addr_o,  32'h0);
        drainCheck("t5");

        // Address wrap, then reset while a read is outstanding.
        $display("[TB] test 6: wrap and reset mid-read");
        resetDut();
        exp_addr_q = '{32'hFFFF_FFFC, 32'h0, 32'h0};
        exp_pc_q   = '{32'h0};
        applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t6_br_mem_re", 32'(mem_re), 32'd0);
        runCycles(3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        @(negedge clk);
        checkOutput("t6_wrap_mem_re", 32'(mem_re), 32'd1);
        checkOutput("t6_wrap_addr",   mem_addr_o,  32'h0);
        checkOutput("t6_wrap_head",   pc_o,        32'hFFFF_FFFC);
        applyStimulus(1'b1, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("t6_rst_mem_re",   32'(mem_re),     32'd0);
        checkOutput("t6_rst_addr",     mem_addr_o,      32'd0);
        checkOutput("t6_rst_pc",       pc_o,            32'd0);
        checkOutput("t6_rst_inst",     inst_o,          32'd0);
        checkOutput("t6_rst_valid",    32'(inst_valid), 32'd0);
        checkOutput("t6_rst_stallreq", 32'(stallreq),   32'd1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t6_post_mem_re", 32'(mem_re), 32'd1);
        checkOutput("t6_post_addr",   mem_addr_o,  32'h0);
        drainCheck("t6");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
